mul8u_rr_share_ctrl: RTL and testbench
======================================

// Module: mul8u_rr_share_ctrl
// PURPOSE
//  Shares one combinational 8x8 unsigned approximate multiplier core among NREQ requesters.
//  Round-robin arbitration, one operation in flight, registered operands and registered result.
//  Each result is returned with the ID of the requester that issued it.
//  Sits between accelerator lanes and a single mul8u core instance, to trade throughput for area/power.
// PARAMETERS
//  NREQ    4   number of requesters (2..8)
//  IDW     2   width of rsp_id; must be >= clog2(NREQ)
//  CNTW    16  width of the saturating completed-operation counter
// PORTS
//  clk        in   1         clock; all logic is on the rising edge
//  rst        in   1         synchronous, active-high reset
//  req_valid  in   NREQ      requester i has an operation pending
//  req_ready  out  NREQ      one-hot grant; operation i is accepted when valid[i] & ready[i]
//  req_a      in   NREQ*8    operand A of requester i, in bits [8i+7:8i]
//  req_b      in   NREQ*8    operand B of requester i, in bits [8i+7:8i]
//  mul_a      out  8         operand A to the multiplier core (registered)
//  mul_b      out  8         operand B to the multiplier core (registered)
//  mul_p      in   16        combinational product returned by the core
//  rsp_valid  out  1         result is available
//  rsp_ready  in   1         consumer accepts the result
//  rsp_id     out  IDW       index of the requester that owns the result
//  rsp_p      out  16        product as delivered by the core (unmodified)
//  busy       out  1         FSM is not in IDLE
//  op_count   out  CNTW      number of completed responses; saturates at all-ones
// BEHAVIOUR
//  Reset values
//   - All outputs are 0.
//   - FSM = IDLE.
//   - Round-robin pointer last = NREQ-1, so requester 0 has first priority.
//  FSM: IDLE -> CALC -> RESP -> IDLE.
//   - IDLE: req_ready is driven combinationally.
//     - It is one-hot on the first i with req_valid[i]=1, searching last+1, last+2, ... modulo NREQ.
//     - It is all zero if no request is valid.
//     - On acceptance: mul_a/mul_b <= operands of i, id <= i, last <= i, state -> CALC.
//   - CALC: req_ready = 0. Capture rsp_p <= mul_p and rsp_id <= id; state -> RESP.
//   - RESP: rsp_valid = 1; rsp_p and rsp_id are held stable.
//     - On rsp_valid & rsp_ready: op_count += 1 (saturating), state -> IDLE.
//     - rsp_valid deasserts on the next cycle.
//  Latency and throughput
//   - Acceptance in cycle t gives rsp_valid=1 in cycle t+2.
//   - Back-to-back throughput is 1 operation per 3 cycles when rsp_ready stays high.
//   - A new request is never accepted while in CALC or RESP; req_ready is 0 there.
//  Handshake rules
//   - req_ready never depends on req_a or req_b.
//   - A requester may drop req_valid at any time before acceptance; no grant is held for it.
//   - rsp_valid stays high until accepted; back-pressure is unbounded.
//  Datapath rules
//   - mul_a/mul_b hold the last accepted operands until the next acceptance; they are not zeroed in IDLE.
//   - No arithmetic is done on the product: 8x8 -> 16 bits, passed through unchanged.
//   - No correction is applied for approximation error.
//  Boundary conditions
//   - Only requester last valid: it is granted again (the wrap-around path).
//   - All requesters valid: grants rotate 0,1,...,NREQ-1,0,...
//   - Reset asserted mid-operation (CALC or RESP): the in-flight operation is dropped with no response.
//     - op_count is cleared and the pointer returns to NREQ-1.
//   - rsp_ready already high on entry to RESP: the transfer completes in that cycle.
// TESTING (bench stub: mul_p = mul_a * mul_b exact; NREQ=4)
//  1. Single request: valid[2]=1, a=0x12, b=0x34 at t0
//     -> ready=4'b0100 at t0; rsp_valid at t0+2 with rsp_id=2, rsp_p=0x03A8; op_count=1.
//  2. All four valid, rsp_ready=1 held
//     -> grant order 0,1,2,3,0; accepts at t, t+3, t+6, t+9; each rsp_id matches its grant.
//  3. Back-pressure: rsp_ready=0 for 5 cycles after rsp_valid, 0xFF*0xFF on req 1
//     -> rsp_p=0xFE01 stable throughout, all req_ready=0, then one transfer.
//  4. Wrap-around: last=3, only valid[3]=1 -> ready=4'b1000. Then valid[0] and valid[3]=1 -> req 0 granted.
//  5. Reset in RESP (rsp_ready=0)
//     -> next cycle: rsp_valid=0, busy=0, op_count=0; a following request on 0 and 1 grants req 0 first.
//  6. Saturation with CNTW=4: 17 completed operations -> op_count stops at 0xF.

Source files
------------

// File: rtl/mul8u_rr_share_ctrl.sv
// mul8u_rr_share_ctrl
//   Shares one combinational 8x8 unsigned (approximate) multiplier core
//   among NREQ requesters. Round-robin arbitration, one operation in
//   flight, registered operands toward the core and a registered result
//   tagged with the ID of the requester that issued it.
//
// Ports
//   clk, rst             rising-edge clock, synchronous active-high reset
//   req_valid[NREQ]      requester i has an operation pending
//   req_ready[NREQ]      one-hot grant, only non-zero in IDLE
//   req_a/req_b          operands of requester i in bits [8i+7:8i]
//   mul_a/mul_b          registered operands to the multiplier core
//   mul_p                combinational product from the core
//   rsp_valid/rsp_ready  result handshake
//   rsp_id, rsp_p        owner and product of the current result
//   busy                 FSM is not in IDLE
//   op_count             completed responses, saturating at all-ones
module mul8u_rr_share_ctrl #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = 2,
    parameter int unsigned CNTW = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*8-1:0] req_a,
    input  logic [NREQ*8-1:0] req_b,
    output logic [7:0]        mul_a,
    output logic [7:0]        mul_b,
    input  logic [15:0]       mul_p,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [15:0]       rsp_p,
    output logic              busy,
    output logic [CNTW-1:0]   op_count
);

    localparam int unsigned SW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        RESP
    } state_t;

    state_t        state, state_d;
    logic [SW-1:0] last;
    logic [SW-1:0] id;
    logic [SW-1:0] gidx;
    logic          found;
    logic [7:0]    sel_a, sel_b;
    int unsigned   pos;

    // Round-robin search starting just after the last granted requester.
    // Depends only on req_valid and the pointer, never on operand values.
    always_comb begin
        found = 1'b0;
        gidx  = '0;
        pos   = 0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            pos = 32'(last) + k;
            if (pos >= NREQ) begin
                pos = pos - NREQ;
            end
            if (!found && req_valid[SW'(pos)]) begin
                found = 1'b1;
                gidx  = SW'(pos);
            end
        end
    end

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (SW'(i) == gidx) begin
                sel_a = req_a[8*i +: 8];
                sel_b = req_b[8*i +: 8];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (state == IDLE && found) begin
            req_ready[gidx] = 1'b1;
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (found) state_d = CALC;
            CALC:    state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign rsp_valid = (state == RESP);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            last     <= SW'(NREQ - 1);
            id       <= '0;
            mul_a    <= '0;
            mul_b    <= '0;
            rsp_p    <= '0;
            rsp_id   <= '0;
            op_count <= '0;
        end else begin
            state <= state_d;
            case (state)
                IDLE: begin
                    if (found) begin
                        mul_a <= sel_a;
                        mul_b <= sel_b;
                        id    <= gidx;
                        last  <= gidx;
                    end
                end
                CALC: begin
                    rsp_p  <= mul_p;
                    rsp_id <= IDW'(id);
                end
                RESP: begin
                    if (rsp_ready && (op_count != '1)) begin
                        op_count <= op_count + CNTW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mul8u_rr_share_ctrl.sv
module tb_mul8u_rr_share_ctrl;

    logic        clk;
    logic        rst;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [7:0]  mul_a;
    logic [7:0]  mul_b;
    logic [15:0] mul_p;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_id;
    logic [15:0] rsp_p;
    logic        busy;
    logic [3:0]  op_count;

    int n_cmp;
    int n_bad;
    int exp_cnt;

    mul8u_rr_share_ctrl #(
        .NREQ(4),
        .IDW (2),
        .CNTW(4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_a    (req_a),
        .req_b    (req_b),
        .mul_a    (mul_a),
        .mul_b    (mul_b),
        .mul_p    (mul_p),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_id   (rsp_id),
        .rsp_p    (rsp_p),
        .busy     (busy),
        .op_count (op_count)
    );

    // exact multiplier stub standing in for the approximate core
    assign mul_p = {8'h00, mul_a} * {8'h00, mul_b};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic set_ops(input int i, input logic [7:0] a, input logic [7:0] b);
        req_a[8*i +: 8] = a;
        req_b[8*i +: 8] = b;
    endtask

    task automatic bump_cnt();
        if (exp_cnt < 15) exp_cnt++;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = '0; rsp_ready = 1'b0; req_a = '0; req_b = '0;
        repeat (3) @(negedge clk);
        #1;
        n_cmp++;
        if ({rsp_valid, busy, op_count, rsp_id, req_ready} !== '0) begin
            n_bad++;
            $display("FAIL reset_ctrl got v=%b busy=%b cnt=%h id=%h rdy=%b exp all 0",
                     rsp_valid, busy, op_count, rsp_id, req_ready);
        end
        n_cmp++;
        if ({mul_a, mul_b, rsp_p} !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_data got a=%h b=%h p=%h exp 0", mul_a, mul_b, rsp_p);
        end
        @(negedge clk);
        rst = 1'b0;
        exp_cnt = 0;
    endtask

    task automatic test_single();
        @(negedge clk);
        req_valid = 4'b0100; set_ops(2, 8'h12, 8'h34); rsp_ready = 1'b1;
        #1;
        n_cmp++;
        if (req_ready !== 4'b0100) begin
            n_bad++; $display("FAIL single_grant got=%b exp=0100", req_ready);
        end
        @(negedge clk);
        req_valid = '0;
        #1;
        n_cmp++;
        if ({busy, rsp_valid, req_ready, mul_a, mul_b} !== {1'b1, 1'b0, 4'b0000, 8'h12, 8'h34}) begin
            n_bad++;
            $display("FAIL single_calc got busy=%b v=%b rdy=%b a=%h b=%h exp 1 0 0000 12 34",
                     busy, rsp_valid, req_ready, mul_a, mul_b);
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if ({rsp_valid, rsp_id, rsp_p} !== {1'b1, 2'd2, 16'h03A8}) begin
            n_bad++;
            $display("FAIL single_resp got v=%b id=%0d p=%h exp 1 2 03a8", rsp_valid, rsp_id, rsp_p);
        end
        bump_cnt();
        @(negedge clk);
        #1;
        n_cmp++;
        if ({rsp_valid, busy, op_count} !== {1'b0, 1'b0, 4'(exp_cnt)}) begin
            n_bad++;
            $display("FAIL single_done got v=%b busy=%b cnt=%0d exp 0 0 %0d", rsp_valid, busy, op_count, exp_cnt);
        end
    endtask

    task automatic test_round_robin();
        logic [15:0] prod [4];
        prod[0] = 16'h0030; prod[1] = 16'h0044; prod[2] = 16'h005A; prod[3] = 16'h0072;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; exp_cnt = 0;
        for (int i = 0; i < 4; i++) set_ops(i, 8'(8'h10 + i), 8'(8'h03 + i));
        req_valid = 4'b1111; rsp_ready = 1'b1;
        for (int g = 0; g < 5; g++) begin
            #1;
            n_cmp++;
            if (req_ready !== 4'(1 << (g % 4))) begin
                n_bad++; $display("FAIL rr_grant%0d got=%b exp=%b", g, req_ready, 4'(1 << (g % 4)));
            end
            @(negedge clk);
            #1;
            n_cmp++;
            if (req_ready !== 4'b0000) begin
                n_bad++; $display("FAIL rr_calc_ready%0d got=%b exp=0000", g, req_ready);
            end
            @(negedge clk);
            #1;
            n_cmp++;
            if ({rsp_valid, rsp_id, rsp_p} !== {1'b1, 2'(g % 4), prod[g % 4]}) begin
                n_bad++;
                $display("FAIL rr_resp%0d got v=%b id=%0d p=%h exp 1 %0d %h",
                         g, rsp_valid, rsp_id, rsp_p, g % 4, prod[g % 4]);
            end
            bump_cnt();
            @(negedge clk);
        end
        req_valid = '0;
        #1;
        n_cmp++;
        if (op_count !== 4'(exp_cnt)) begin
            n_bad++; $display("FAIL rr_count got=%0d exp=%0d", op_count, exp_cnt);
        end
    endtask

    task automatic test_back_pressure();
        @(negedge clk);
        req_valid = 4'b0010; set_ops(1, 8'hFF, 8'hFF); rsp_ready = 1'b0;
        #1;
        n_cmp++;
        if (req_ready !== 4'b0010) begin
            n_bad++; $display("FAIL bp_grant got=%b exp=0010", req_ready);
        end
        @(negedge clk);
        req_valid = 4'b1101;
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            #1;
            n_cmp++;
            if ({rsp_valid, rsp_id, rsp_p, req_ready, mul_a} !== {1'b1, 2'd1, 16'hFE01, 4'b0000, 8'hFF}) begin
                n_bad++;
                $display("FAIL bp_hold%0d got v=%b id=%0d p=%h rdy=%b a=%h exp 1 1 fe01 0000 ff",
                         k, rsp_valid, rsp_id, rsp_p, req_ready, mul_a);
            end
            @(negedge clk);
        end
        req_valid = '0; rsp_ready = 1'b1;
        #1;
        n_cmp++;
        if (rsp_valid !== 1'b1) begin
            n_bad++; $display("FAIL bp_still_valid got=%b exp=1", rsp_valid);
        end
        bump_cnt();
        @(negedge clk);
        #1;
        n_cmp++;
        if ({rsp_valid, op_count} !== {1'b0, 4'(exp_cnt)}) begin
            n_bad++; $display("FAIL bp_done got v=%b cnt=%0d exp 0 %0d", rsp_valid, op_count, exp_cnt);
        end
    endtask

    task automatic test_wrap();
        logic [3:0] vec [3];
        int         idx [3];
        vec[0] = 4'b1000; idx[0] = 3;
        vec[1] = 4'b1000; idx[1] = 3;
        vec[2] = 4'b1001; idx[2] = 0;
        rsp_ready = 1'b1;
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            req_valid = vec[s];
            #1;
            n_cmp++;
            if (req_ready !== 4'(1 << idx[s])) begin
                n_bad++; $display("FAIL wrap_grant%0d got=%b exp=%b", s, req_ready, 4'(1 << idx[s]));
            end
            @(negedge clk);
            req_valid = '0;
            @(negedge clk);
            #1;
            n_cmp++;
            if (rsp_id !== 2'(idx[s])) begin
                n_bad++; $display("FAIL wrap_id%0d got=%0d exp=%0d", s, rsp_id, idx[s]);
            end
            bump_cnt();
        end
        @(negedge clk);
    endtask

    task automatic test_reset_in_resp();
        @(negedge clk);
        req_valid = 4'b0100; set_ops(2, 8'h05, 8'h07); rsp_ready = 1'b0;
        #1;
        n_cmp++;
        if (req_ready !== 4'b0100) begin
            n_bad++; $display("FAIL rst_mid_grant got=%b exp=0100", req_ready);
        end
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        #1;
        n_cmp++;
        if ({rsp_valid, rsp_p} !== {1'b1, 16'h0023}) begin
            n_bad++; $display("FAIL rst_mid_resp got v=%b p=%h exp 1 0023", rsp_valid, rsp_p);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; exp_cnt = 0;
        #1;
        n_cmp++;
        if ({rsp_valid, busy, op_count, rsp_p} !== '0) begin
            n_bad++;
            $display("FAIL rst_mid_clear got v=%b busy=%b cnt=%0d p=%h exp all 0", rsp_valid, busy, op_count, rsp_p);
        end
        req_valid = 4'b0011; rsp_ready = 1'b1;
        #1;
        n_cmp++;
        if (req_ready !== 4'b0001) begin
            n_bad++; $display("FAIL rst_mid_ptr got=%b exp=0001", req_ready);
        end
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        #1;
        n_cmp++;
        if (rsp_id !== 2'd0) begin
            n_bad++; $display("FAIL rst_mid_id got=%0d exp=0", rsp_id);
        end
        bump_cnt();
        @(negedge clk);
    endtask

    task automatic test_saturation();
        logic [7:0] a, b;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; exp_cnt = 0; rsp_ready = 1'b1;
        for (int n = 1; n <= 17; n++) begin
            a = 8'(n); b = 8'(n + 2);
            req_valid = 4'b0001; set_ops(0, a, b);
            @(negedge clk);
            req_valid = '0;
            @(negedge clk);
            #1;
            n_cmp++;
            if (rsp_p !== 16'(n * (n + 2))) begin
                n_bad++; $display("FAIL sat_prod%0d got=%h exp=%h", n, rsp_p, 16'(n * (n + 2)));
            end
            bump_cnt();
            @(negedge clk);
            #1;
            n_cmp++;
            if (op_count !== 4'(exp_cnt)) begin
                n_bad++; $display("FAIL sat_count%0d got=%0d exp=%0d", n, op_count, exp_cnt);
            end
        end
    endtask

    initial begin
        n_cmp = 0; n_bad = 0; exp_cnt = 0;
        test_reset();
        test_single();
        test_round_robin();
        test_back_pressure();
        test_wrap();
        test_reset_in_resp();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
